pong_mmio_ctrl: RTL and testbench

Memory-mapped I/O controller between the processor's data port, data memory, PS/2 receiver and VGA controller. It decodes CPU data accesses and gates data-memory writes. It buffers keyboard scan codes in a small FIFO so no keypress is lost between polls. It double-buffers the game-state registers (ball, paddles, score) and commits them to the VGA controller only on a vertical-sync edge, so no frame is drawn from a half-updated state.

---
 rtl/pong_mmio_pkg.sv | 31 +++
 rtl/pong_mmio_ctrl_if.sv | 10 +
 rtl/pong_key_fifo.sv | 57 +++++
 rtl/pong_mmio_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pong_mmio_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_mmio_pkg.sv
// Shared constants for the pong MMIO controller: register offsets, game-state
// reset values, status bit positions and the commit FSM encoding.
package pong_mmio_pkg;

  localparam logic [11:0] OFF_KEY      = 12'd0;
  localparam logic [11:0] OFF_KEY_HEAD = 12'd1;
  localparam logic [11:0] OFF_STATUS   = 12'd2;
  localparam logic [11:0] OFF_BALL_X   = 12'd10;
  localparam logic [11:0] OFF_BALL_Y   = 12'd11;
  localparam logic [11:0] OFF_PAD_L    = 12'd12;
  localparam logic [11:0] OFF_PAD_R    = 12'd13;
  localparam logic [11:0] OFF_SCORE    = 12'd14;
  localparam logic [11:0] OFF_COMMIT   = 12'd15;

  localparam logic [9:0] RST_BALL_X = 10'd315;
  localparam logic [9:0] RST_BALL_Y = 10'd235;
  localparam logic [8:0] RST_PADDLE = 9'd220;
  localparam logic [7:0] RST_SCORE  = 8'd0;

  localparam int STAT_OVERFLOW_BIT = 5;
  localparam int STAT_PENDING_BIT  = 6;
  localparam int STAT_VSYNC_BIT    = 7;
  localparam int STAT_FRAME_LSB    = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } commit_state_e;

endpackage

// File: rtl/pong_mmio_ctrl_if.sv
// Processor data-port bus: address, store data, store strobe and load data.
interface pong_mmio_ctrl_if;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_wren;
  logic [31:0] cpu_rdata;

  modport master (output cpu_addr, output cpu_wdata, output cpu_wren, input cpu_rdata);
  modport slave  (input cpu_addr, input cpu_wdata, input cpu_wren, output cpu_rdata);
endinterface

// File: rtl/pong_key_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is dropped unless a pop in
// the same cycle frees the slot, and the drop is flagged for one cycle.
module pong_key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             dropped
);

  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dropped = push && !push_ok;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pong_mmio_ctrl.sv
// MMIO controller: address decode, key FIFO, and double-buffered game state
// that is committed to the VGA side only on a vsync falling edge.
module pong_mmio_ctrl
  import pong_mmio_pkg::*;
#(
  parameter int KEY_FIFO_DEPTH = 4,
  parameter int MMIO_BASE      = 2000
) (
  input  logic                    clock,
  input  logic                    resetn,
  pong_mmio_ctrl_if.slave         cpu,
  input  logic [31:0]             dmem_q,
  output logic                    dmem_wren,
  input  logic                    ps2_key_pressed,
  input  logic [7:0]              ps2_key_data,
  input  logic                    vga_vs,
  output logic [9:0]              ball_x,
  output logic [9:0]              ball_y,
  output logic [8:0]              paddle_left_y,
  output logic [8:0]              paddle_right_y,
  output logic [7:0]              score
);

  localparam int          KAW  = $clog2(KEY_FIFO_DEPTH);
  localparam logic [11:0] BASE = 12'(MMIO_BASE);

  logic [11:0]   offset;
  logic          is_mmio;
  logic          wr_mmio;
  logic          wr_commit;
  logic          vs_q;
  logic          vs_fall;
  logic          key_q;
  logic          key_edge;
  logic [7:0]    last_key;
  logic          overflow;
  logic [15:0]   frame_count;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [KAW:0]  fifo_count;
  logic          fifo_dropped;
  logic [9:0]    sh_ball_x;
  logic [9:0]    sh_ball_y;
  logic [8:0]    sh_pad_l;
  logic [8:0]    sh_pad_r;
  logic [7:0]    sh_score;
  commit_state_e state_q;
  commit_state_e state_d;
  logic          unused_wdata;

  assign is_mmio      = (cpu.cpu_addr >= BASE);
  assign offset       = cpu.cpu_addr - BASE;
  assign wr_mmio      = cpu.cpu_wren && is_mmio;
  assign wr_commit    = wr_mmio && (offset == OFF_COMMIT);
  assign dmem_wren    = cpu.cpu_wren && !is_mmio;
  assign vs_fall      = vs_q && !vga_vs;
  assign key_edge     = ps2_key_pressed && !key_q;
  assign unused_wdata = ^cpu.cpu_wdata[31:10];

  pong_key_fifo #(
    .DEPTH (KEY_FIFO_DEPTH),
    .WIDTH (8)
  ) u_key_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (key_edge),
    .push_data (ps2_key_data),
    .pop       (wr_mmio && (offset == OFF_KEY_HEAD)),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .dropped   (fifo_dropped)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vs_q        <= 1'b1;
      key_q       <= 1'b0;
      last_key    <= '0;
      overflow    <= 1'b0;
      frame_count <= '0;
    end else begin
      vs_q  <= vga_vs;
      key_q <= ps2_key_pressed;
      if (key_edge) last_key <= ps2_key_data;
      // A drop in the same cycle as a clear leaves the flag set.
      if (fifo_dropped)                               overflow <= 1'b1;
      else if (wr_mmio && (offset == OFF_STATUS))     overflow <= 1'b0;
      if (vs_fall) frame_count <= frame_count + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sh_ball_x      <= RST_BALL_X;
      sh_ball_y      <= RST_BALL_Y;
      sh_pad_l       <= RST_PADDLE;
      sh_pad_r       <= RST_PADDLE;
      sh_score       <= RST_SCORE;
      ball_x         <= RST_BALL_X;
      ball_y         <= RST_BALL_Y;
      paddle_left_y  <= RST_PADDLE;
      paddle_right_y <= RST_PADDLE;
      score          <= RST_SCORE;
    end else begin
      if (wr_mmio && (offset == OFF_BALL_X)) sh_ball_x <= cpu.cpu_wdata[9:0];
      if (wr_mmio && (offset == OFF_BALL_Y)) sh_ball_y <= cpu.cpu_wdata[9:0];
      if (wr_mmio && (offset == OFF_PAD_L))  sh_pad_l  <= cpu.cpu_wdata[8:0];
      if (wr_mmio && (offset == OFF_PAD_R))  sh_pad_r  <= cpu.cpu_wdata[8:0];
      if (wr_mmio && (offset == OFF_SCORE))  sh_score  <= cpu.cpu_wdata[7:0];
      if (state_q == ST_COMMIT) begin
        ball_x         <= sh_ball_x;
        ball_y         <= sh_ball_y;
        paddle_left_y  <= sh_pad_l;
        paddle_right_y <= sh_pad_r;
        score          <= sh_score;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // A commit request arriving from IDLE only arms the FSM, so a request made
  // on the same edge as vsync waits for the following frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (wr_commit) state_d = ST_PENDING;
      ST_PENDING: if (vs_fall)   state_d = ST_COMMIT;
      ST_COMMIT:  state_d = wr_commit ? ST_PENDING : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu.cpu_rdata = '0;
    if (!is_mmio) begin
      cpu.cpu_rdata = dmem_q;
    end else begin
      case (offset)
        OFF_KEY:      cpu.cpu_rdata[7:0] = last_key;
        OFF_KEY_HEAD: if (!fifo_empty) cpu.cpu_rdata[8:0] = {1'b1, fifo_head};
        OFF_STATUS: begin
          cpu.cpu_rdata[KAW:0]             = fifo_count;
          cpu.cpu_rdata[STAT_OVERFLOW_BIT] = overflow;
          cpu.cpu_rdata[STAT_PENDING_BIT]  = (state_q == ST_PENDING);
          cpu.cpu_rdata[STAT_VSYNC_BIT]    = !vs_q;
          cpu.cpu_rdata[31:STAT_FRAME_LSB] = frame_count;
        end
        OFF_BALL_X:   cpu.cpu_rdata[9:0] = sh_ball_x;
        OFF_BALL_Y:   cpu.cpu_rdata[9:0] = sh_ball_y;
        OFF_PAD_L:    cpu.cpu_rdata[8:0] = sh_pad_l;
        OFF_PAD_R:    cpu.cpu_rdata[8:0] = sh_pad_r;
        OFF_SCORE:    cpu.cpu_rdata[7:0] = sh_score;
        default:      cpu.cpu_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_mmio_ctrl.sv
// Scoreboard bench for pong_mmio_ctrl: stimulus tasks queue hand-computed
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_pong_mmio_ctrl;

  localparam int SEL_RDATA = 0;
  localparam int SEL_WREN  = 1;
  localparam int SEL_BX    = 2;
  localparam int SEL_BY    = 3;
  localparam int SEL_PL    = 4;
  localparam int SEL_PR    = 5;
  localparam int SEL_SCORE = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic        clock;
  logic        resetn;
  logic [31:0] dmem_q;
  logic        dmem_wren;
  logic        ps2_key_pressed;
  logic [7:0]  ps2_key_data;
  logic        vga_vs;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic [8:0]  paddle_left_y;
  logic [8:0]  paddle_right_y;
  logic [7:0]  score;

  exp_t sb[$];
  int   total;
  int   bad;

  pong_mmio_ctrl_if bus();

  pong_mmio_ctrl #(
    .KEY_FIFO_DEPTH (4),
    .MMIO_BASE      (2000)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .cpu             (bus),
    .dmem_q          (dmem_q),
    .dmem_wren       (dmem_wren),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_key_data    (ps2_key_data),
    .vga_vs          (vga_vs),
    .ball_x          (ball_x),
    .ball_y          (ball_y),
    .paddle_left_y   (paddle_left_y),
    .paddle_right_y  (paddle_right_y),
    .score           (score)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Monitor: every queued expectation is compared on the next falling edge.
  always @(negedge clock) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_RDATA: act = bus.cpu_rdata;
        SEL_WREN:  act = {31'b0, dmem_wren};
        SEL_BX:    act = {22'b0, ball_x};
        SEL_BY:    act = {22'b0, ball_y};
        SEL_PL:    act = {23'b0, paddle_left_y};
        SEL_PR:    act = {23'b0, paddle_right_y};
        SEL_SCORE: act = {24'b0, score};
        default:   act = 32'hxxxx_xxxx;
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one bus cycle (store when wr=1) across a single clock edge.
  task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] data, input logic wr);
    bus.cpu_addr  = addr;
    bus.cpu_wdata = data;
    bus.cpu_wren  = wr;
    tick();
    bus.cpu_wren  = 1'b0;
  endtask

  task automatic pressKey(input logic [7:0] code);
    ps2_key_data    = code;
    ps2_key_pressed = 1'b1;
    tick();
    ps2_key_pressed = 1'b0;
    tick();
  endtask

  // Present an address, queue the expected value and let the monitor consume it.
  task automatic checkOutput(input string name, input int sel, input logic [11:0] addr,
                             input logic wr, input logic [31:0] exp);
    bus.cpu_addr = addr;
    bus.cpu_wren = wr;
    sb.push_back('{name, sel, exp});
    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: monitor left %0d entries, wanted 0", name, sb.size());
      sb.delete();
    end
    bus.cpu_wren = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, wanted test end");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] keys [5];
    keys[0] = 8'h1D; keys[1] = 8'h1B; keys[2] = 8'h1C; keys[3] = 8'h23; keys[4] = 8'h75;
    total = 0;
    bad   = 0;
    resetn          = 1'b0;
    bus.cpu_addr    = '0;
    bus.cpu_wdata   = '0;
    bus.cpu_wren    = 1'b0;
    dmem_q          = 32'hDEAD_BEEF;
    ps2_key_pressed = 1'b0;
    ps2_key_data    = '0;
    vga_vs          = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    tick();

    $display("[TB] reset values");
    checkOutput("rst_ball_x",  SEL_BX,    12'd0,    1'b0, 32'd315);
    checkOutput("rst_ball_y",  SEL_BY,    12'd0,    1'b0, 32'd235);
    checkOutput("rst_pad_l",   SEL_PL,    12'd0,    1'b0, 32'd220);
    checkOutput("rst_pad_r",   SEL_PR,    12'd0,    1'b0, 32'd220);
    checkOutput("rst_score",   SEL_SCORE, 12'd0,    1'b0, 32'd0);
    checkOutput("rst_status",  SEL_RDATA, 12'd2002, 1'b0, 32'h0000_0000);
    checkOutput("rst_sh_bx",   SEL_RDATA, 12'd2010, 1'b0, 32'd315);

    $display("[TB] commit waits for vsync");
    applyStimulus(12'd2010, 32'd100, 1'b1);
    checkOutput("sh_bx_100",   SEL_RDATA, 12'd2010, 1'b0, 32'd100);
    applyStimulus(12'd2015, 32'd0, 1'b1);
    repeat (50) tick();
    checkOutput("pending_stat", SEL_RDATA, 12'd2002, 1'b0, 32'h0000_0040);
    checkOutput("bx_held",     SEL_BX,    12'd0,    1'b0, 32'd315);
    vga_vs = 1'b0;
    tick();
    checkOutput("bx_1cyc",     SEL_BX,    12'd0,    1'b0, 32'd315);
    tick();
    checkOutput("bx_commit",   SEL_BX,    12'd0,    1'b0, 32'd100);
    checkOutput("stat_frame1", SEL_RDATA, 12'd2002, 1'b0, 32'h0001_0080);
    vga_vs = 1'b1;
    tick();

    $display("[TB] key fifo");
    for (int i = 0; i < 5; i++) pressKey(keys[i]);
    checkOutput("fifo_full_ovf", SEL_RDATA, 12'd2002, 1'b0, 32'h0001_0024);
    for (int i = 0; i < 4; i++) begin
      checkOutput("fifo_head", SEL_RDATA, 12'd2001, 1'b0, {23'b0, 1'b1, keys[i]});
      applyStimulus(12'd2001, 32'hFFFF_FFFF, 1'b1);
    end
    checkOutput("fifo_empty",   SEL_RDATA, 12'd2001, 1'b0, 32'h0000_0000);
    applyStimulus(12'd2001, 32'd0, 1'b1);
    checkOutput("pop_empty",    SEL_RDATA, 12'd2002, 1'b0, 32'h0001_0020);
    applyStimulus(12'd2002, 32'd0, 1'b1);
    checkOutput("ovf_clear",    SEL_RDATA, 12'd2002, 1'b0, 32'h0001_0000);
    pressKey(8'h2A);
    checkOutput("last_key",     SEL_RDATA, 12'd2000, 1'b0, 32'h0000_002A);
    checkOutput("head_2a",      SEL_RDATA, 12'd2001, 1'b0, 32'h0000_012A);
    applyStimulus(12'd2001, 32'd0, 1'b1);

    $display("[TB] commit request on the vsync edge");
    applyStimulus(12'd2011, 32'd50, 1'b1);
    vga_vs = 1'b0;
    applyStimulus(12'd2015, 32'd0, 1'b1);
    tick();
    checkOutput("by_no_commit", SEL_BY,    12'd0,    1'b0, 32'd235);
    checkOutput("stat_edge",    SEL_RDATA, 12'd2002, 1'b0, 32'h0002_00C0);
    vga_vs = 1'b1;
    tick();
    vga_vs = 1'b0;
    tick();
    tick();
    checkOutput("by_next_vs",   SEL_BY,    12'd0,    1'b0, 32'd50);
    checkOutput("stat_frame3",  SEL_RDATA, 12'd2002, 1'b0, 32'h0003_0080);
    vga_vs = 1'b1;
    tick();

    $display("[TB] shadow write during commit");
    applyStimulus(12'd2014, 32'd7, 1'b1);
    applyStimulus(12'd2015, 32'd0, 1'b1);
    vga_vs = 1'b0;
    tick();
    applyStimulus(12'd2014, 32'd9, 1'b1);
    checkOutput("score_old_sh", SEL_SCORE, 12'd0,    1'b0, 32'd7);
    checkOutput("sh_score_new", SEL_RDATA, 12'd2014, 1'b0, 32'd9);
    vga_vs = 1'b1;
    tick();

    $display("[TB] write gating and read decode");
    checkOutput("wren_dmem",   SEL_WREN,  12'd1999, 1'b1, 32'd1);
    checkOutput("wren_mmio",   SEL_WREN,  12'd2010, 1'b1, 32'd0);
    checkOutput("wren_idle",   SEL_WREN,  12'd1999, 1'b0, 32'd0);
    applyStimulus(12'd2010, 32'd123, 1'b1);
    checkOutput("sh_bx_123",   SEL_RDATA, 12'd2010, 1'b0, 32'd123);
    checkOutput("load_dmem",   SEL_RDATA, 12'd500,  1'b0, 32'hDEAD_BEEF);
    checkOutput("unmapped",    SEL_RDATA, 12'd2005, 1'b0, 32'd0);

    $display("[TB] reset mid operation");
    applyStimulus(12'd2015, 32'd0, 1'b1);
    pressKey(8'h11);
    pressKey(8'h22);
    checkOutput("pre_rst_stat", SEL_RDATA, 12'd2002, 1'b0, 32'h0004_0042);
    resetn = 1'b0;
    checkOutput("mid_rst_stat", SEL_RDATA, 12'd2002, 1'b0, 32'h0000_0000);
    checkOutput("mid_rst_head", SEL_RDATA, 12'd2001, 1'b0, 32'h0000_0000);
    checkOutput("mid_rst_bx",   SEL_BX,    12'd0,    1'b0, 32'd315);
    checkOutput("mid_rst_by",   SEL_BY,    12'd0,    1'b0, 32'd235);
    checkOutput("mid_rst_sc",   SEL_SCORE, 12'd0,    1'b0, 32'd0);
    checkOutput("mid_rst_shbx", SEL_RDATA, 12'd2010, 1'b0, 32'd315);
    tick();
    resetn = 1'b1;
    tick();
    checkOutput("post_rst_stat", SEL_RDATA, 12'd2002, 1'b0, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
